// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: SDRAM read engine for the frame-buffer path (OV5640 -> SDRAM -> VGA).
// Latency: ACT->READ after T_RCD clocks, first DQ beat CAS_LAT+1 clocks after READ, one slot = CAS_LAT+BURST_LEN+1.
// Backpressure: none on data (read FIFO must take every data_vld beat); bus is yielded to refresh only at a burst boundary.
//
// Requests the bus from the arbiter, activates the current row, issues BURSTS_PER_REQ reads of BURST_LEN
// beats, precharges all banks and walks column/row/bank addresses across a frame of ROWS_USED rows.
// Optional build macro: SDRAM_RD_PINGPONG_EN adds wr_bank; on frame wrap the reader then selects the
// bank half the writer is not filling. Without it, the bank simply increments on every frame wrap.
//
// Ports:
//   sysclk_100M    system clock            rst_n          async active-low reset
//   read_trig      start a transaction     refresh_req    refresh pending, yield at next burst boundary
//   arb_req/ack    bus request / grant     arb_done       transaction complete / bus not owned
//   arb_prech_done pulse after PRE wait    cmd            {CS_n,RAS_n,CAS_n,WE_n}
//   sdram_addr     address bus             sdram_bank     bank address
//   data_vld       DQ beat valid           frame_done     pulse on wrap to row 0 / col 0
//   wr_bank        writer's bank (SDRAM_RD_PINGPONG_EN only)

module sdram_burst_reader #(
   parameter int ROW_W          = 13,
   parameter int COL_W          = 9,
   parameter int ROWS_USED      = 8192,
   parameter int BURST_LEN      = 8,
   parameter int CAS_LAT        = 3,
   parameter int T_RCD          = 2,
   parameter int T_RP           = 2,
   parameter int BURSTS_PER_REQ = 32
) (
   input  logic             sysclk_100M,
   input  logic             rst_n,
   input  logic             read_trig,
   input  logic             refresh_req,
   output logic             arb_req,
   input  logic             arb_ack,
   output logic             arb_done,
   output logic             arb_prech_done,
   output logic [3:0]       cmd,
   output logic [ROW_W-1:0] sdram_addr,
   output logic [1:0]       sdram_bank,
   output logic             data_vld,
`ifdef SDRAM_RD_PINGPONG_EN
   input  logic [1:0]       wr_bank,
`endif
   output logic             frame_done
);

   localparam int SLOT      = CAS_LAT + BURST_LEN + 1;
   localparam int CNT_MAX_A = (SLOT > T_RCD) ? SLOT : T_RCD;
   localparam int CNT_MAX   = (CNT_MAX_A > T_RP) ? CNT_MAX_A : T_RP;
   localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam int BCNT_W    = (BURSTS_PER_REQ > 1) ? $clog2(BURSTS_PER_REQ) : 1;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_READ = 4'b0101;
   localparam logic [3:0] CMD_PRE  = 4'b0010;

   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0]  RCD_LAST   = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0]  RP_LAST    = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0]  VLD_FIRST  = CNT_W'(CAS_LAT + 1);
   localparam logic [CNT_W-1:0]  VLD_LAST   = CNT_W'(CAS_LAT + BURST_LEN);
   localparam logic [COL_W-1:0]  COL_STEP   = COL_W'(BURST_LEN);
   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'((1 << COL_W) - BURST_LEN);
   localparam logic [ROW_W-1:0]  ROW_ONE    = ROW_W'(1);
   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS_USED - 1);
   localparam logic [ROW_W-1:0]  ADDR_A10   = ROW_W'(1024);
   localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);
   localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURSTS_PER_REQ - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_READ, S_PRE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ROW_W-1:0]  row, row_nxt;
   logic [COL_W-1:0]  col, col_nxt;
   logic [BCNT_W-1:0] burst_cnt, burst_nxt;
   logic              done_q, done_nxt;
   logic              row_end_q, row_end_nxt;
   logic [1:0]        bank_nxt;
   logic [3:0]        cmd_nxt;
   logic [ROW_W-1:0]  addr_nxt;
   logic              arb_req_nxt, arb_done_nxt, prech_done_nxt, data_vld_nxt, frame_done_nxt;

   logic col_is_last, row_is_last, burst_is_last;

   assign col_is_last   = (col == COL_LAST);
   assign row_is_last   = (row == ROW_LAST);
   assign burst_is_last = (burst_cnt == BURST_LAST);

   always_ff @(posedge sysclk_100M or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         row            <= '0;
         col            <= '0;
         burst_cnt      <= '0;
         done_q         <= 1'b0;
         row_end_q      <= 1'b0;
         cmd            <= CMD_NOP;
         sdram_addr     <= ADDR_A10;
         sdram_bank     <= '0;
         arb_req        <= 1'b0;
         arb_done       <= 1'b1;
         arb_prech_done <= 1'b0;
         data_vld       <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         row            <= row_nxt;
         col            <= col_nxt;
         burst_cnt      <= burst_nxt;
         done_q         <= done_nxt;
         row_end_q      <= row_end_nxt;
         cmd            <= cmd_nxt;
         sdram_addr     <= addr_nxt;
         sdram_bank     <= bank_nxt;
         arb_req        <= arb_req_nxt;
         arb_done       <= arb_done_nxt;
         arb_prech_done <= prech_done_nxt;
         data_vld       <= data_vld_nxt;
         frame_done     <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      row_nxt        = row;
      col_nxt        = col;
      burst_nxt      = burst_cnt;
      done_nxt       = done_q;
      row_end_nxt    = row_end_q;
      bank_nxt       = sdram_bank;
      arb_done_nxt   = arb_done;
      prech_done_nxt = 1'b0;
      frame_done_nxt = 1'b0;
      cmd_nxt        = CMD_NOP;
      addr_nxt       = sdram_addr;

      case (state)
         S_IDLE: begin
            if (read_trig) begin
               state_nxt = S_REQ;
               cnt_nxt   = '0;
            end
         end

         S_REQ: begin
            if (arb_ack) begin
               state_nxt    = S_ACT;
               cnt_nxt      = '0;
               arb_done_nxt = 1'b0;
               row_end_nxt  = 1'b0;
            end
         end

         S_ACT: begin
            if (cnt == RCD_LAST) begin
               state_nxt = S_READ;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         S_READ: begin
            // Decisions are taken only at the slot end so a started burst always
            // delivers all of its beats before any PRE.
            if (cnt == SLOT_LAST) begin
               cnt_nxt   = '0;
               col_nxt   = col + COL_STEP;
               burst_nxt = burst_cnt + BCNT_ONE;
               if (col_is_last) begin
                  row_end_nxt = 1'b1;
                  if (row_is_last) begin
                     row_nxt        = '0;
                     frame_done_nxt = 1'b1;
`ifdef SDRAM_RD_PINGPONG_EN
                     bank_nxt       = wr_bank ^ 2'b10;
`else
                     bank_nxt       = sdram_bank + 2'd1;
`endif
                  end else begin
                     row_nxt = row + ROW_ONE;
                  end
               end
               if (burst_is_last) begin
                  done_nxt     = 1'b1;
                  arb_done_nxt = 1'b1;
                  burst_nxt    = '0;
               end
               if (burst_is_last || refresh_req || col_is_last) begin
                  state_nxt = S_PRE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         S_PRE: begin
            if (cnt == RP_LAST) begin
               cnt_nxt        = '0;
               prech_done_nxt = 1'b1;
               if (done_q) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b0;
               end else if (refresh_req) begin
                  // Re-arbitrate; the burst counter is kept so the transaction
                  // still totals BURSTS_PER_REQ bursts.
                  state_nxt = S_REQ;
               end else begin
                  state_nxt   = S_ACT;
                  row_end_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Registered outputs are derived from the state being entered, so a
      // command appears on the pins in the first cycle of its state.
      arb_req_nxt  = (state_nxt == S_REQ);
      data_vld_nxt = (state_nxt == S_READ) && (cnt_nxt >= VLD_FIRST) && (cnt_nxt <= VLD_LAST);
      if (cnt_nxt == '0) begin
         case (state_nxt)
            S_ACT: begin
               cmd_nxt  = CMD_ACT;
               addr_nxt = row_nxt;
            end
            S_READ: begin
               cmd_nxt  = CMD_READ;
               addr_nxt = ROW_W'(col_nxt);   // A10=0: no auto-precharge
            end
            S_PRE: begin
               cmd_nxt  = CMD_PRE;
               addr_nxt = ADDR_A10;          // all banks
            end
            default: ;
         endcase
      end
   end

endmodule
